// File: rtl/tone_note_scheduler_if.sv
// tone_note_scheduler_if
//   Groups the control inputs and status outputs of tone_note_scheduler.
//   master: the controller side (drives key/play/stop/loop, observes status).
//   slave : the scheduler itself.
//   Signals:
//     key[6:0]      live keys, key[0] highest priority, key[k] selects tone k
//     play          start melody, only honoured while idle
//     stop          abort melody, wins over play in the same cycle
//     loop          restart at entry 0 on reaching an END entry
//     audio         square-wave output, 0 whenever silent
//     busy          sequencer is in PLAY or GAP (also while frozen)
//     live          registered |key
//     note_idx[3:0] current melody entry index
//     done          one-cycle pulse when the melody ends without looping
//     seq_state     debug view of the sequencer FSM (0 IDLE, 1 PLAY, 2 GAP)
//   Control semantics: there is no valid/ready pairing here. Every input is
//   level-sampled on each rising clock edge; play is a request that is simply
//   dropped unless the sequencer is idle and not frozen, stop is always taken.
interface tone_note_scheduler_if;
    logic [6:0] key;
    logic       play;
    logic       stop;
    logic       loop;
    logic       audio;
    logic       busy;
    logic       live;
    logic [3:0] note_idx;
    logic       done;
    logic [1:0] seq_state;

    modport master (
        output key, play, stop, loop,
        input  audio, busy, live, note_idx, done, seq_state
    );

    modport slave (
        input  key, play, stop, loop,
        output audio, busy, live, note_idx, done, seq_state
    );
endinterface

// File: rtl/tone_note_scheduler.sv
// tone_note_scheduler
//   Melody sequencer plus live-key arbiter driving a square-wave tone divider.
//   Plays a 16-entry melody of (tone, beats) entries with an optional silent
//   gap after each entry. Any live key preempts the sequencer, which freezes
//   in place and resumes where it stopped once all keys are released.
//   Ports:
//     clk    clock, everything on the rising edge
//     rst_n  synchronous active-low reset
//     bus    tone_note_scheduler_if.slave (key/play/stop/loop in,
//            audio/busy/live/note_idx/done/seq_state out)
//   Melody entry i = MELODY[8i+7:8i]: [7]=END, [6:4]=tone (7=rest),
//   [3:0]=beats (0 plays as 1 beat).
module tone_note_scheduler #(
    parameter int          BEAT_CYCLES = 64,
    parameter int          GAP_CYCLES  = 8,
    parameter int          HP_0        = 28,
    parameter int          HP_1        = 25,
    parameter int          HP_2        = 24,
    parameter int          HP_3        = 21,
    parameter int          HP_4        = 19,
    parameter int          HP_5        = 18,
    parameter int          HP_6        = 16,
    parameter logic [127:0] MELODY     = 128'h00000000_00000000_00000000_80712102
) (
    input logic                  clk,
    input logic                  rst_n,
    tone_note_scheduler_if.slave bus
);
    localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0]    SILENT    = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [3:0]    idx, idx_n;
    logic [BW-1:0] beat_cnt, beat_n;
    logic [3:0]    dur_cnt, dur_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic          done_r, done_n;
    logic          live_r, live_n;
    logic [2:0]    ltone_n;
    logic [2:0]    sel_r, sel_n;
    logic [7:0]    hp_cnt;
    logic          audio_r;

    // Melody field accessors.
    function automatic logic end_at(input logic [3:0] i);
        return MELODY[{i, 3'b111}];
    endfunction

    function automatic logic [2:0] tone_at(input logic [3:0] i);
        return MELODY[{i, 3'b100} +: 3];
    endfunction

    function automatic logic [3:0] beats_at(input logic [3:0] i);
        return MELODY[{i, 3'b000} +: 4];
    endfunction

    // Reload value (half period minus one) for a tone.
    function automatic logic [7:0] hp_reload(input logic [2:0] t);
        logic [7:0] r;
        case (t)
            3'd0:    r = 8'(HP_0 - 1);
            3'd1:    r = 8'(HP_1 - 1);
            3'd2:    r = 8'(HP_2 - 1);
            3'd3:    r = 8'(HP_3 - 1);
            3'd4:    r = 8'(HP_4 - 1);
            3'd5:    r = 8'(HP_5 - 1);
            3'd6:    r = 8'(HP_6 - 1);
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    // Where the sequencer goes once the current entry (and its gap) is over.
    // The next entry is looked at in the same cycle, so an END entry takes no
    // play time: it either restarts entry 0 or finishes. Running off the end
    // of the table (index 15 done) behaves like END.
    logic [4:0] nxt;
    logic       at_end;
    state_t     adv_state;
    logic [3:0] adv_idx;
    logic       adv_done;
    logic [3:0] beats;
    logic [3:0] last_beat;

    always_comb begin : advance
        nxt       = {1'b0, idx} + 5'd1;
        at_end    = nxt[4] | end_at(nxt[3:0]);
        adv_state = PLAY;
        adv_idx   = nxt[3:0];
        adv_done  = 1'b0;
        if (at_end) begin
            if (bus.loop && !end_at(4'd0)) begin
                adv_idx = 4'd0;
            end else begin
                adv_state = IDLE;
                adv_done  = 1'b1;
            end
        end
        beats     = beats_at(idx);
        last_beat = (beats == 4'd0) ? 4'd0 : beats - 4'd1;
    end

    always_comb begin : seq_next
        state_n = state;
        idx_n   = idx;
        beat_n  = beat_cnt;
        dur_n   = dur_cnt;
        gap_n   = gap_cnt;
        done_n  = 1'b0;
        if (bus.stop) begin
            state_n = IDLE;
            idx_n   = 4'd0;
            beat_n  = '0;
            dur_n   = 4'd0;
            gap_n   = '0;
        end else if (!live_r) begin
            // While live_r is high everything above holds its value.
            case (state)
                IDLE: begin
                    if (bus.play) begin
                        if (end_at(4'd0)) begin
                            done_n = 1'b1;
                        end else begin
                            state_n = PLAY;
                            idx_n   = 4'd0;
                            beat_n  = '0;
                            dur_n   = 4'd0;
                            gap_n   = '0;
                        end
                    end
                end
                PLAY: begin
                    if (beat_cnt == BEAT_LAST) begin
                        beat_n = '0;
                        if (dur_cnt == last_beat) begin
                            dur_n = 4'd0;
                            if (GAP_CYCLES > 0) begin
                                state_n = GAP;
                                gap_n   = '0;
                            end else begin
                                state_n = adv_state;
                                idx_n   = adv_idx;
                                done_n  = adv_done;
                            end
                        end else begin
                            dur_n = dur_cnt + 4'd1;
                        end
                    end else begin
                        beat_n = beat_cnt + BW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_n   = '0;
                        state_n = adv_state;
                        idx_n   = adv_idx;
                        done_n  = adv_done;
                    end else begin
                        gap_n = gap_cnt + GW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Tone selection is computed from next-cycle values so that the divider
    // restarts on the same edge the selection changes; the first rising edge
    // then lands HP cycles after the tone starts.
    always_comb begin : tone_select
        live_n  = |bus.key;
        ltone_n = 3'd0;
        for (int k = 6; k >= 0; k--) begin
            if (bus.key[k]) ltone_n = 3'(k);
        end
        if (live_n) begin
            sel_n = ltone_n;
        end else if (state_n == PLAY) begin
            sel_n = tone_at(idx_n);   // a rest entry yields SILENT
        end else begin
            sel_n = SILENT;
        end
    end

    always_ff @(posedge clk) begin : seq_reg
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 4'd0;
            beat_cnt <= '0;
            dur_cnt  <= 4'd0;
            gap_cnt  <= '0;
            done_r   <= 1'b0;
            live_r   <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            beat_cnt <= beat_n;
            dur_cnt  <= dur_n;
            gap_cnt  <= gap_n;
            done_r   <= done_n;
            live_r   <= live_n;
        end
    end

    always_ff @(posedge clk) begin : tone_gen
        if (!rst_n) begin
            sel_r   <= SILENT;
            hp_cnt  <= 8'd0;
            audio_r <= 1'b0;
        end else if (sel_n != sel_r) begin
            // Selection change restarts the wave low; going silent keeps hp_cnt.
            sel_r   <= sel_n;
            audio_r <= 1'b0;
            if (sel_n != SILENT) hp_cnt <= hp_reload(sel_n);
        end else if (sel_r != SILENT) begin
            if (hp_cnt == 8'd0) begin
                audio_r <= ~audio_r;
                hp_cnt  <= hp_reload(sel_r);
            end else begin
                hp_cnt <= hp_cnt - 8'd1;
            end
        end
    end

    assign bus.audio     = audio_r;
    assign bus.busy      = (state != IDLE);
    assign bus.live      = live_r;
    assign bus.note_idx  = idx;
    assign bus.done      = done_r;
    assign bus.seq_state = state;
endmodule

// File: tb/tb_tone_note_scheduler.sv
module tb_tone_note_scheduler;
    localparam int BEAT = 4;
    localparam int GAP  = 2;
    localparam int HP0 = 3, HP1 = 2, HP2 = 2, HP3 = 21, HP4 = 19, HP5 = 18, HP6 = 16;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tone_note_scheduler_if bus();

    tone_note_scheduler #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP),
        .HP_0       (HP0),
        .HP_1       (HP1),
        .HP_2       (HP2),
        .HP_3       (HP3),
        .HP_4       (HP4),
        .HP_5       (HP5),
        .HP_6       (HP6),
        .MELODY     (128'h00000000_00000000_00000000_80712102)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d t=%0t got=%0h expected=%0h", name, cyc, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The melody is flattened into a list of timed segments (notes, rests,
    // gaps). The sequencer is a pointer into that list; audio follows from
    // how long the current selection has been active.
    logic [127:0] melody_v = 128'h00000000_00000000_00000000_80712102;
    int           seg_len[$];
    logic [2:0]   seg_tone[$];
    logic [3:0]   seg_idx[$];
    logic [3:0]   end_idx;

    bit         m_busy = 0, m_live = 0, m_done = 0;
    int         m_seg = 0, m_off = 0, m_age = 0;
    logic [2:0] m_ltone = 3'd0, m_prev_sel = 3'd7;
    logic [3:0] m_idle_idx = 4'd0;

    function automatic int hp_of(input logic [2:0] t);
        case (t)
            3'd0: return HP0;
            3'd1: return HP1;
            3'd2: return HP2;
            3'd3: return HP3;
            3'd4: return HP4;
            3'd5: return HP5;
            3'd6: return HP6;
            default: return 1;
        endcase
    endfunction

    task automatic build_schedule();
        logic [7:0] e;
        int beats;
        end_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            e = melody_v[8*i +: 8];
            if (e[7]) begin
                end_idx = 4'(i);
                break;
            end
            beats = (e[3:0] == 4'd0) ? 1 : int'(e[3:0]);
            seg_len.push_back(beats * BEAT); seg_tone.push_back(e[6:4]); seg_idx.push_back(4'(i));
            if (GAP > 0) begin
                seg_len.push_back(GAP); seg_tone.push_back(3'd7); seg_idx.push_back(4'(i));
            end
        end
    endtask

    always @(posedge clk) begin : model_step
        logic [2:0] s;
        if (!rst_n) begin
            m_busy = 0; m_live = 0; m_done = 0; m_seg = 0; m_off = 0;
            m_idle_idx = 4'd0; m_prev_sel = 3'd7; m_age = 0;
        end else begin
            m_done = 0;
            if (bus.stop) begin
                m_busy = 0;
                m_idle_idx = 4'd0;
            end else if (!m_live) begin
                if (!m_busy) begin
                    if (bus.play) begin
                        m_busy = 1; m_seg = 0; m_off = 0;
                    end
                end else begin
                    m_off++;
                    if (m_off == seg_len[m_seg]) begin
                        m_off = 0;
                        m_seg++;
                        if (m_seg == seg_len.size()) begin
                            m_seg = 0;
                            if (!bus.loop) begin
                                m_busy = 0; m_done = 1; m_idle_idx = end_idx;
                            end
                        end
                    end
                end
            end
            m_live = |bus.key;
            m_ltone = 3'd0;
            for (int k = 0; k < 7; k++) begin
                if (bus.key[k]) begin
                    m_ltone = 3'(k);
                    break;
                end
            end
            if (m_live) s = m_ltone;
            else if (m_busy) s = seg_tone[m_seg];
            else s = 3'd7;
            if (s != m_prev_sel) m_age = 0;
            else m_age++;
            m_prev_sel = s;
        end
    end

    // scoreboard: every cycle against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_audio", 32'(bus.audio),
                32'((m_prev_sel != 3'd7) && (((m_age / hp_of(m_prev_sel)) % 2) == 1)));
            chk("m_busy", 32'(bus.busy), 32'(m_busy));
            chk("m_live", 32'(bus.live), 32'(m_live));
            chk("m_done", 32'(bus.done), 32'(m_done));
            chk("m_idx", 32'(bus.note_idx), 32'(m_busy ? seg_idx[m_seg] : m_idle_idx));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.key = 7'd0; bus.play = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        chk_en = 1'b1;
    endtask

    // play pulse in cycle 0 (after this task returns)
    task automatic start_play();
        reset_dut();
        bus.play = 1'b1;
        cyc = 0;
        step_to(1);
        bus.play = 1'b0;
    endtask

    // ---------------- table-driven melody run ----------------
    typedef struct {
        int         cyc;
        logic       lp;
        logic       audio;
        logic       busy;
        logic [3:0] idx;
        logic       done;
    } vec_t;
    vec_t vecs[$];

    task automatic run_table(input logic lp);
        reset_dut();
        bus.loop = lp;
        bus.play = 1'b1;
        cyc = 0;
        for (int c = 0; c <= 27; c++) begin
            step_to(c);
            if (c == 1) bus.play = 1'b0;
            @(negedge clk);
            foreach (vecs[v]) begin
                if (vecs[v].lp == lp && vecs[v].cyc == c) begin
                    chk("tbl_audio", 32'(bus.audio), 32'(vecs[v].audio));
                    chk("tbl_busy", 32'(bus.busy), 32'(vecs[v].busy));
                    chk("tbl_idx", 32'(bus.note_idx), 32'(vecs[v].idx));
                    chk("tbl_done", 32'(bus.done), 32'(vecs[v].done));
                end
            end
        end
    endtask

    int         key_hold;
    logic [6:0] cur_key;

    initial begin
        build_schedule();
        bus.key = 7'd0; bus.play = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;

        // reset state
        reset_dut();
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_audio", 32'(bus.audio), 32'd0);
        chk("rst_live", 32'(bus.live), 32'd0);
        chk("rst_idx", 32'(bus.note_idx), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);

        // cyc, loop, audio, busy, note_idx, done
        vecs.push_back('{0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
        vecs.push_back('{1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0});
        vecs.push_back('{3, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0});
        vecs.push_back('{4, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0});
        vecs.push_back('{6, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0});
        vecs.push_back('{7, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0});
        vecs.push_back('{9, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0});
        vecs.push_back('{10, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0});
        vecs.push_back('{11, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0});
        vecs.push_back('{13, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0});
        vecs.push_back('{15, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0});
        vecs.push_back('{17, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0});
        vecs.push_back('{19, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0});
        vecs.push_back('{21, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0});
        vecs.push_back('{22, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0});
        vecs.push_back('{23, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1});
        vecs.push_back('{24, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0});
        vecs.push_back('{22, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0});
        vecs.push_back('{23, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0});
        vecs.push_back('{24, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0});
        vecs.push_back('{26, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0});
        vecs.push_back('{27, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0});
        run_table(1'b0);
        run_table(1'b1);

        // live key override: keys 1 and 2 held cycles 5..10, tone 1 wins
        start_play();
        step_to(5);  bus.key = 7'b0000110;
        step_to(6);  @(negedge clk);
        chk("key_live_on", 32'(bus.live), 32'd1);
        chk("key_idx_hold", 32'(bus.note_idx), 32'd0);
        chk("key_audio_start", 32'(bus.audio), 32'd0);
        step_to(8);  @(negedge clk);
        chk("key_tone1_high", 32'(bus.audio), 32'd1);
        step_to(10); @(negedge clk);
        chk("key_tone1_low", 32'(bus.audio), 32'd0);
        step_to(11); bus.key = 7'd0; @(negedge clk);
        chk("key_live_latency", 32'(bus.live), 32'd1);
        step_to(12); @(negedge clk);
        chk("key_live_off", 32'(bus.live), 32'd0);
        chk("key_resume_busy", 32'(bus.busy), 32'd1);
        chk("key_resume_idx", 32'(bus.note_idx), 32'd0);
        step_to(15); @(negedge clk);
        chk("key_gap_idx", 32'(bus.note_idx), 32'd0);
        chk("key_gap_audio", 32'(bus.audio), 32'd0);
        step_to(17); @(negedge clk);
        chk("key_next_entry", 32'(bus.note_idx), 32'd1);

        // stop beats play
        start_play();
        step_to(12); bus.play = 1'b1; bus.stop = 1'b1;
        step_to(13); bus.play = 1'b0; bus.stop = 1'b0; @(negedge clk);
        chk("stop_busy", 32'(bus.busy), 32'd0);
        chk("stop_idx", 32'(bus.note_idx), 32'd0);
        chk("stop_audio", 32'(bus.audio), 32'd0);
        chk("stop_done", 32'(bus.done), 32'd0);
        step_to(14); @(negedge clk);
        chk("stop_stays_idle", 32'(bus.busy), 32'd0);
        chk("stop_no_done", 32'(bus.done), 32'd0);

        // reset mid-note, play and key ignored while in reset
        start_play();
        step_to(5); rst_n = 1'b0; bus.play = 1'b1; bus.key = 7'b0000001;
        step_to(6); rst_n = 1'b1; bus.play = 1'b0; bus.key = 7'd0; @(negedge clk);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_audio", 32'(bus.audio), 32'd0);
        chk("mid_rst_live", 32'(bus.live), 32'd0);
        chk("mid_rst_idx", 32'(bus.note_idx), 32'd0);
        step_to(7); @(negedge clk);
        chk("mid_rst_play_ignored", 32'(bus.busy), 32'd0);

        // play while busy is ignored
        start_play();
        step_to(3);  bus.play = 1'b1;
        step_to(4);  bus.play = 1'b0; @(negedge clk);
        chk("rebusy_idx", 32'(bus.note_idx), 32'd0);
        step_to(12); bus.play = 1'b1;
        step_to(13); bus.play = 1'b0; @(negedge clk);
        chk("rebusy_idx1", 32'(bus.note_idx), 32'd1);
        chk("rebusy_audio", 32'(bus.audio), 32'd1);
        step_to(23); @(negedge clk);
        chk("rebusy_done", 32'(bus.done), 32'd1);

        // randomized run, checked against the model every cycle
        reset_dut();
        key_hold = 0;
        cur_key  = 7'd0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            cyc++;
            rst_n    = ($urandom_range(0, 799) != 0);
            bus.play = ($urandom_range(0, 7) == 0);
            bus.stop = ($urandom_range(0, 149) == 0);
            bus.loop = 1'($urandom_range(0, 1));
            if (key_hold == 0 && $urandom_range(0, 39) == 0) begin
                cur_key  = 7'($urandom_range(1, 127));
                key_hold = $urandom_range(1, 10);
            end
            bus.key = (key_hold > 0) ? cur_key : 7'd0;
            if (key_hold > 0) key_hold--;
        end
        @(posedge clk); #1;
        bus.key = 7'd0; bus.play = 1'b0; bus.stop = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
